// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: cycle-accurate observer for the R/G/Y lamp outputs
// of the traffic-light controller. An internal expected-phase model runs on
// time and the pass request only; observed lamps are compared to it every
// cycle and mismatches are reported as a registered pulse plus a saturating
// count.
module traffic_light_monitor #(
  parameter int T_G0 = 1024,
  parameter int T_N  = 128,
  parameter int T_G  = 128,
  parameter int T_Y  = 512,
  parameter int T_R  = 1024,
  parameter int CW   = 11,
  parameter int EW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pass,
  input  logic          check_en,
  input  logic          R,
  input  logic          G,
  input  logic          Y,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [EW-1:0] err_cnt,
  output logic [2:0]    phase
);

  typedef enum logic [2:0] {
    S_G0 = 3'd0,
    S_N0 = 3'd1,
    S_G1 = 3'd2,
    S_N1 = 3'd3,
    S_G2 = 3'd4,
    S_Y  = 3'd5,
    S_R  = 3'd6
  } state_t;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_MULTI = 2'd1;
  localparam logic [1:0] E_WRONG = 2'd2;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, last;
  logic [2:0]    obs, exp_lamps;
  logic          multi, restart, wrap;
  logic          err_d;
  logic [1:0]    code_d;

  assign obs   = {R, G, Y};
  assign multi = (R & G) | (R & Y) | (G & Y);
  assign wrap  = (cnt == last);
  assign phase = state;

  // Pass restarts the long green only from the pedestrian-facing phases.
  assign restart = pass && (state == S_N0 || state == S_G1 ||
                            state == S_N1 || state == S_G2);

  // Phase length (as terminal count) and expected lamps {R,G,Y} per state.
  always_comb begin
    last      = CW'(T_G0 - 1);
    exp_lamps = 3'b010;
    case (state)
      S_G0: begin last = CW'(T_G0 - 1); exp_lamps = 3'b010; end
      S_N0: begin last = CW'(T_N  - 1); exp_lamps = 3'b000; end
      S_G1: begin last = CW'(T_G  - 1); exp_lamps = 3'b010; end
      S_N1: begin last = CW'(T_N  - 1); exp_lamps = 3'b000; end
      S_G2: begin last = CW'(T_G  - 1); exp_lamps = 3'b010; end
      S_Y:  begin last = CW'(T_Y  - 1); exp_lamps = 3'b001; end
      S_R:  begin last = CW'(T_R  - 1); exp_lamps = 3'b100; end
      default: begin last = CW'(T_G0 - 1); exp_lamps = 3'b010; end
    endcase
  end

  // Sequence successor used when the current phase runs out.
  always_comb begin
    state_nxt = S_G0;
    case (state)
      S_G0:    state_nxt = S_N0;
      S_N0:    state_nxt = S_G1;
      S_G1:    state_nxt = S_N1;
      S_N1:    state_nxt = S_G2;
      S_G2:    state_nxt = S_Y;
      S_Y:     state_nxt = S_R;
      S_R:     state_nxt = S_G0;
      default: state_nxt = S_G0;
    endcase
  end

  // Classify this cycle's sample. Multi-lamp wins over a plain mismatch;
  // an unknown compare result falls to the mismatch branch.
  always_comb begin
    err_d  = 1'b0;
    code_d = E_NONE;
    if (check_en) begin
      if (multi) begin
        err_d  = 1'b1;
        code_d = E_MULTI;
      end else if (obs == exp_lamps) begin
        err_d  = 1'b0;
        code_d = E_NONE;
      end else begin
        err_d  = 1'b1;
        code_d = E_WRONG;
      end
    end
  end

  // Expected-phase model: pass restart overrides normal advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_G0;
      cnt   <= '0;
    end else if (restart) begin
      state <= S_G0;
      cnt   <= '0;
    end else if (wrap) begin
      state <= state_nxt;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // Registered error pulse and saturating count (count moves with the pulse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= E_NONE;
      err_cnt  <= '0;
    end else begin
      err      <= err_d;
      err_code <= code_d;
      if (err_d && (err_cnt != {EW{1'b1}}))
        err_cnt <= err_cnt + EW'(1);
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: ideal lamps, injected faults,
// pass handling, saturation on a narrow counter, async reset, check_en.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst_n, pass, check_en, R, G, Y;
  logic        err, err4;
  logic [1:0]  err_code, err_code4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;
  logic [2:0]  phase, phase4;

  int vecs = 0;
  int bad  = 0;
  int cyc  = 0;   // index of the cycle whose inputs are currently driven
  int t0   = 0;   // cycle at which the current G0 period started
  int errs = 0;   // err pulses seen on the default-width instance

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk(clk), .rst_n(rst_n), .pass(pass), .check_en(check_en),
    .R(R), .G(G), .Y(Y),
    .err(err), .err_code(err_code), .err_cnt(err_cnt), .phase(phase)
  );

  traffic_light_monitor #(.EW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pass(pass), .check_en(check_en),
    .R(R), .G(G), .Y(Y),
    .err(err4), .err_code(err_code4), .err_cnt(err_cnt4), .phase(phase4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected phase from position within the 3072-cycle period.
  function automatic logic [2:0] phase_at(input int k);
    int m;
    m = (k - t0) % 3072;
    if (m < 1024)      return 3'd0;
    else if (m < 1152) return 3'd1;
    else if (m < 1280) return 3'd2;
    else if (m < 1408) return 3'd3;
    else if (m < 1536) return 3'd4;
    else if (m < 2048) return 3'd5;
    else               return 3'd6;
  endfunction

  function automatic logic [2:0] lamps_of(input logic [2:0] p);
    case (p)
      3'd1, 3'd3: return 3'b000;
      3'd5:       return 3'b001;
      3'd6:       return 3'b100;
      default:    return 3'b010;
    endcase
  endfunction

  // Apply one cycle of inputs, clock it, then check the expected phase.
  task automatic step(input logic [2:0] lamps, input logic p, input logic ce);
    logic [2:0] cur;
    {R, G, Y} = lamps;
    pass      = p;
    check_en  = ce;
    cur = phase_at(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (p && cur >= 3'd1 && cur <= 3'd4) t0 = cyc;
    if (err) errs++;
    chk("phase", {29'd0, phase}, {29'd0, phase_at(cyc)});
  endtask

  task automatic ideal_until(input int k);
    while (cyc < k) step(lamps_of(phase_at(cyc)), 1'b0, 1'b1);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    pass = 1'b0; check_en = 1'b1; {R, G, Y} = 3'b010;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; t0 = 0; errs = 0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; pass = 1'b0; check_en = 1'b1; {R, G, Y} = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_err",   {31'd0, err},      32'd0);
    chk("rst_code",  {30'd0, err_code}, 32'd0);
    chk("rst_cnt",   {16'd0, err_cnt},  32'd0);
    chk("rst_phase", {29'd0, phase},    32'd0);
    rst_n = 1'b1;
    cyc = 0; t0 = 0; errs = 0;

    // Ideal lamps for two full periods
    while (cyc < 6144) begin
      step(lamps_of(phase_at(cyc)), 1'b0, 1'b1);
      if (cyc == 1535) chk("ph1535", {29'd0, phase}, 32'd4);
      if (cyc == 1536) chk("ph1536", {29'd0, phase}, 32'd5);
      if (cyc == 3071) chk("ph3071", {29'd0, phase}, 32'd6);
      if (cyc == 3072) chk("ph3072", {29'd0, phase}, 32'd0);
    end
    chk("ideal_errs", errs, 0);
    chk("ideal_cnt", {16'd0, err_cnt}, 32'd0);

    // Wrong lamp at cycle 10, then multi-lamp in R at 2100
    do_reset();
    ideal_until(10);
    step(3'b001, 1'b0, 1'b1);
    chk("wr_err",  {31'd0, err},      32'd1);
    chk("wr_code", {30'd0, err_code}, 32'd2);
    chk("wr_cnt",  {16'd0, err_cnt},  32'd1);
    step(lamps_of(phase_at(cyc)), 1'b0, 1'b1);
    chk("wr_err_off",  {31'd0, err},      32'd0);
    chk("wr_code_off", {30'd0, err_code}, 32'd0);
    ideal_until(2100);
    step(3'b110, 1'b0, 1'b1);
    chk("multi_err",  {31'd0, err},      32'd1);
    chk("multi_code", {30'd0, err_code}, 32'd1);
    chk("multi_cnt",  {16'd0, err_cnt},  32'd2);
    step(lamps_of(phase_at(cyc)), 1'b0, 1'b1);
    chk("multi_off", {31'd0, err}, 32'd0);

    // Pass in N1 at 1300 restarts G0 at 1301
    do_reset();
    ideal_until(1300);
    step(3'b000, 1'b1, 1'b1);
    chk("pass_n1", {29'd0, phase}, 32'd0);
    ideal_until(2324);
    chk("ph2324", {29'd0, phase}, 32'd0);
    step(lamps_of(phase_at(cyc)), 1'b0, 1'b1);
    chk("ph2325", {29'd0, phase}, 32'd1);
    chk("pass_cnt", {16'd0, err_cnt}, 32'd0);

    // Pass in Y at 1700 is ignored
    do_reset();
    ideal_until(1700);
    step(3'b001, 1'b1, 1'b1);
    chk("pass_y", {29'd0, phase}, 32'd5);
    ideal_until(2047);
    chk("ph2047", {29'd0, phase}, 32'd5);
    step(lamps_of(phase_at(cyc)), 1'b0, 1'b1);
    chk("ph2048", {29'd0, phase}, 32'd6);

    // Pass on G0's last cycle: normal advance; on G2's last cycle: restart;
    // a held pass in N0 restarts once
    do_reset();
    ideal_until(1023);
    step(3'b010, 1'b1, 1'b1);
    chk("g0_wrap_pass", {29'd0, phase}, 32'd1);
    ideal_until(1535);
    step(3'b010, 1'b1, 1'b1);
    chk("g2_wrap_pass", {29'd0, phase}, 32'd0);
    ideal_until(1536 + 1100);
    repeat (10) step(lamps_of(phase_at(cyc)), 1'b1, 1'b1);
    ideal_until(1536 + 1101 + 1024);
    chk("held_pass", {29'd0, phase}, 32'd1);
    chk("pass_errs", errs, 0);

    // Lamps stuck off for 2000 cycles: narrow counter saturates
    do_reset();
    while (cyc < 2000) step(3'b000, 1'b0, 1'b1);
    chk("sat4",  {28'd0, err_cnt4}, 32'd15);
    chk("cnt16", {16'd0, err_cnt},  32'd1744);
    // Async reset mid-cycle, observed before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt4",  {28'd0, err_cnt4}, 32'd0);
    chk("arst_cnt",   {16'd0, err_cnt},  32'd0);
    chk("arst_phase", {29'd0, phase4},   32'd0);
    chk("arst_err",   {31'd0, err4},     32'd0);

    // check_en low suppresses errors; model keeps tracking
    do_reset();
    ideal_until(100);
    while (cyc < 200) step(3'b100, 1'b0, 1'b0);
    ideal_until(400);
    chk("ce_errs", errs, 0);
    chk("ce_cnt", {16'd0, err_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Synthesizable observer for the R/G/Y lamp outputs of the traffic-light controller. It sits on the receiving end of the lamp interface, beside the controller or in an on-chip self-check wrapper. It runs a cycle-accurate expected-phase model, driven by the same pass request the controller sees, and compares the observed lamps against it every cycle. It reports per-cycle errors, a saturating error count and the current expected phase.

Parameters:
T_G0, 1024, cycles of the long green phase
T_N, 128, cycles of each lamps-off phase
T_G, 128, cycles of each short green phase
T_Y, 512, cycles of the yellow phase
T_R, 1024, cycles of the red phase
CW, 11, phase-counter width; must hold max(T_*)-1
EW, 16, error-counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pass  in  1  pedestrian pass request, same signal the controller receives
check_en  in  1  1 = compare and count errors; 0 = model advances, no errors flagged
R  in  1  observed red lamp
G  in  1  observed green lamp
Y  in  1  observed yellow lamp
err  out  1  registered one-cycle pulse per mismatching cycle
err_code  out  2  0 none, 1 illegal multi-lamp, 2 wrong lamp; valid with err
err_cnt  out  EW  saturating count of err pulses
phase  out  3  expected phase: 0 G0, 1 N0, 2 G1, 3 N1, 4 G2, 5 Y, 6 R

Behaviour:
- Clock and reset: one clock domain. rst_n low asynchronously clears state to G0, counter to 0, err=0, err_code=0, err_cnt=0, phase=0. The first edge after release samples the first G0 cycle.
- Phase sequence: G0(T_G0) -> N0(T_N) -> G1(T_G) -> N1(T_N) -> G2(T_G) -> Y(T_Y) -> R(T_R) -> G0.
  - Default period is 3072 cycles.
  - Expected lamps {R,G,Y}: G phases 010, N phases 000, Y 001, R 100.
- Counter: phase counter runs 0..T-1 in each phase. At T-1 it clears and the state advances on the same edge.
- Pass request:
  - If pass=1 is sampled at an edge while the state is N0, G1, N1 or G2, the next state is G0 with counter 0. This overrides normal advance, including an edge at which the phase would have ended.
  - pass is ignored in G0, Y and R.
  - A multi-cycle pass in a qualifying phase restarts G0 once; subsequent cycles are in G0 and are ignored.
- Comparison (every edge with check_en=1), using the observed lamps against the expectation for the current state:
  - More than one lamp high -> err_code 1. This takes priority over code 2.
  - Otherwise, any mismatch -> err_code 2.
  - err and err_code are registered and appear one cycle after the offending sample. err_code returns to 0 when err=0.
- Errors do not resynchronize the model; the expected phase always follows time and pass only.
- err_cnt increments on each err pulse and saturates at 2^EW-1.
- check_en=0 suppresses err and the increment for that cycle only; the model still advances.
- phase output is the state register, combinational from the flop.
- Boundary cases:
  - Counter wrap at T-1 with pass in a non-qualifying phase: normal advance.
  - Reset mid-phase: immediate return to G0/0 and err_cnt cleared.
  - X/Z on lamps: treated as mismatch (err_code 2).

Test Plan:
- Ideal lamp model for 6144 cycles, pass=0 -> err never asserted, err_cnt=0. phase=5 at cycle 1536, phase=0 again at cycle 3072.
- Force Y=1 instead of G at cycle 10 only -> err=1 at cycle 11 only, err_code=2, err_cnt=1.
- Drive R=1,G=1 at cycle 2100 (R phase) -> err_code=1 (not 2), err_cnt increments by 1.
- One-cycle pass at cycle 1300 (N1), ideal lamps restarting G0 at 1301 -> phase=0 at 1301, phase=1 at 2325, no errors. Pass at cycle 1700 (Y) -> ignored, phase stays 5 until 2048.
- EW=4 and lamps stuck at 000 for 2000 cycles -> err_cnt reaches 15 and holds. Then rst_n low asynchronously mid-cycle -> err_cnt=0 and phase=0 before the next edge.
- check_en=0 for cycles 100-199 with wrong lamps -> no err. Re-enable with correct lamps -> err_cnt still 0, phase tracking unaffected.
